// File: rtl/alu_seq.sv
// Registered ALU for the EX stage. Logic/add/sub/compare ops complete in
// one cycle; multiply, unsigned divide and unsigned remainder iterate one
// bit per cycle for WIDTH cycles while busy_o stalls the pipeline.
//
// Handshake: a request is accepted on a rising edge where the block is idle
// and start_i=1; operands and ctrl_i are captured on that edge. done_o is a
// one-cycle pulse marking the cycle in which a new result_o is valid.
// start_i is ignored while busy_o=1 and is never queued.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  src1_i,
    input  logic [WIDTH-1:0]  src2_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [WIDTH-1:0]  result_o,
    output logic              zero_o,
    output logic              ovf_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(12);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    // op_a: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // op_b: multiplier (MUL) or divisor (DIV)
    // acc : product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0]   op_a, op_a_nxt;
    logic [WIDTH-1:0]   op_b, op_b_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt;
    logic               want_rem, want_rem_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic               zero_nxt, ovf_nxt, busy_nxt, done_nxt;

    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   mul_sum;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               take;

    // Single-cycle result and signed overflow straight from the live inputs
    always_comb begin
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_NOR:  alu_res = ~(src1_i | src2_i);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                          (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                          (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply and of restoring division.
    // A zero divisor always "fits", giving an all-ones quotient and leaving
    // the dividend as remainder, so no special case is needed.
    always_comb begin
        mul_sum   = acc + (op_b[0] ? op_a : '0);
        rem_shift = {acc, op_a[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, op_b};
        take      = ~rem_diff[WIDTH];
    end

    // Next-state and datapath updates; everything holds unless changed
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        op_a_nxt     = op_a;
        op_b_nxt     = op_b;
        acc_nxt      = acc;
        want_rem_nxt = want_rem;
        result_nxt   = result_o;
        ovf_nxt      = ovf_o;
        busy_nxt     = busy_o;
        done_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (ctrl_i == OP_MUL || ctrl_i == OP_DIVU || ctrl_i == OP_REMU) begin
                        state_nxt    = (ctrl_i == OP_MUL) ? ST_MUL : ST_DIV;
                        busy_nxt     = 1'b1;
                        count_nxt    = CNT_W'(WIDTH);
                        acc_nxt      = '0;
                        op_a_nxt     = src1_i;
                        op_b_nxt     = src2_i;
                        want_rem_nxt = (ctrl_i == OP_REMU);
                    end else begin
                        result_nxt = alu_res;
                        ovf_nxt    = alu_ovf;
                        done_nxt   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_nxt   = mul_sum;
                op_a_nxt  = {op_a[WIDTH-2:0], 1'b0};
                op_b_nxt  = {1'b0, op_b[WIDTH-1:1]};
                count_nxt = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    result_nxt = mul_sum;
                    ovf_nxt    = 1'b0;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    state_nxt  = ST_IDLE;
                end
            end
            ST_DIV: begin
                acc_nxt   = take ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                op_a_nxt  = {op_a[WIDTH-2:0], take};
                count_nxt = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    result_nxt = want_rem ? acc_nxt : op_a_nxt;
                    ovf_nxt    = 1'b0;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
        zero_nxt = (result_nxt == '0);
    end

    // State and datapath registers; reset discards any in-flight op
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            count    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            want_rem <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b1;
            ovf_o    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            op_a     <= op_a_nxt;
            op_b     <= op_b_nxt;
            acc      <= acc_nxt;
            want_rem <= want_rem_nxt;
            result_o <= result_nxt;
            zero_o   <= zero_nxt;
            ovf_o    <= ovf_nxt;
            busy_o   <= busy_nxt;
            done_o   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance share clock
// and reset. The driver pushes the hand-computed response into a per-DUT
// expected queue; monitors pop and compare whenever done_o is seen.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_n;

    logic        start32, zero32, ovf32, busy32, done32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  ctrl32;

    logic        start8, zero8, ovf8, busy8, done8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  ctrl8;

    int checks   = 0;
    int failures = 0;

    logic [33:0] exp32_q[$];
    logic [9:0]  exp8_q[$];
    logic [33:0] e32;
    logic [9:0]  e8;

    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_MUL = 4'd3,
                           C_DIVU = 4'd5, C_SUB = 4'd6, C_SLT = 4'd7, C_SLTU = 4'd8,
                           C_REMU = 4'd9, C_NOR = 4'd12, C_BAD = 4'd15;

    // clock
    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .CTRL_W(4)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start32), .src1_i(a32), .src2_i(b32),
        .ctrl_i(ctrl32), .result_o(res32), .zero_o(zero32), .ovf_o(ovf32),
        .busy_o(busy32), .done_o(done32)
    );

    alu_seq #(.WIDTH(8), .CTRL_W(4)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start8), .src1_i(a8), .src2_i(b8),
        .ctrl_i(ctrl8), .result_o(res8), .zero_o(zero8), .ovf_o(ovf8),
        .busy_o(busy8), .done_o(done8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done32 : done8;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy32 : busy8;
    endfunction

    // scoreboard monitor, 32-bit instance
    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (exp32_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done32 actual=done required=no_done");
            end else begin
                e32 = exp32_q.pop_front();
                chk("result32", 64'(res32), 64'(e32[31:0]));
                chk("zero32", 64'(zero32), 64'(e32[32]));
                chk("ovf32", 64'(ovf32), 64'(e32[33]));
            end
        end
    end

    // scoreboard monitor, 8-bit instance
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done8 actual=done required=no_done");
            end else begin
                e8 = exp8_q.pop_front();
                chk("result8", 64'(res8), 64'(e8[7:0]));
                chk("zero8", 64'(zero8), 64'(e8[8]));
                chk("ovf8", 64'(ovf8), 64'(e8[9]));
            end
        end
    end

    // Issue one op (called #1 after a rising edge). Single-cycle ops must show
    // done_o right after the accepting edge; iterative ops are timed and must
    // finish WIDTH cycles later with busy_o high for exactly WIDTH cycles.
    task automatic run_op(input int sel, input logic [3:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic ovf,
                          input bit iter, input string name);
        int cyc;
        int busy_n;
        int w;
        w = (sel == 0) ? 32 : 8;
        if (sel == 0) begin
            start32 = 1'b1; ctrl32 = ctrl; a32 = a; b32 = b;
            exp32_q.push_back({ovf, (res == 32'd0), res});
        end else begin
            start8 = 1'b1; ctrl8 = ctrl; a8 = a[7:0]; b8 = b[7:0];
            exp8_q.push_back({ovf, (res[7:0] == 8'd0), res[7:0]});
        end
        @(posedge clk); #1;
        start32 = 1'b0;
        start8  = 1'b0;
        if (!iter) begin
            chk({name, "_done"}, 64'(done_of(sel)), 64'd1);
        end else begin
            cyc = 0;
            busy_n = 0;
            while (done_of(sel) !== 1'b1 && cyc < 200) begin
                if (busy_of(sel) === 1'b1) busy_n++;
                @(posedge clk); #1;
                cyc++;
            end
            chk({name, "_latency"}, 64'(cyc), 64'(w));
            chk({name, "_busy_cycles"}, 64'(busy_n), 64'(w));
            chk({name, "_busy_end"}, 64'(busy_of(sel)), 64'd0);
        end
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; ctrl32 = '0;
        start8  = 1'b0; a8  = '0; b8  = '0; ctrl8  = '0;
        #12;
        chk("rst_result32", 64'(res32), 64'd0);
        chk("rst_zero32", 64'(zero32), 64'd1);
        chk("rst_ovf32", 64'(ovf32), 64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_result8", 64'(res8), 64'd0);
        chk("rst_zero8", 64'(zero8), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-cycle ops back-to-back
        run_op(0, C_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1'b0, "add_ovf");
        run_op(0, C_SUB,  32'd5,         32'd5,         32'h0,         1'b0, 1'b0, "sub_zero");
        run_op(0, C_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, "slt");
        run_op(0, C_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, "sltu");
        run_op(0, C_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, "nor");
        run_op(0, C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, "and");
        run_op(0, C_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, "or");
        run_op(0, C_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b0, "sub_ovf");
        run_op(0, C_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, "add_wrap");
        run_op(0, C_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, "nor2");

        // reset in the middle of a multiply: result discarded, no done pulse
        start32 = 1'b1; ctrl32 = C_MUL; a32 = 32'd7; b32 = 32'd9;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy32), 64'd0);
        chk("midrst_result", 64'(res32), 64'd0);
        chk("midrst_zero", 64'(zero32), 64'd1);
        chk("midrst_done", 64'(done32), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_idle_result", 64'(res32), 64'd0);
        run_op(0, C_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "add_after_rst");

        // multiply
        run_op(0, C_MUL, 32'h0001_0003, 32'h5,         32'h0005_000F, 1'b0, 1'b1, "mul_a");
        run_op(0, C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, "mul_ones");

        // divide and remainder, including divide by zero
        run_op(0, C_DIVU, 32'd100, 32'd7, 32'd14,        1'b0, 1'b1, "divu");
        run_op(0, C_REMU, 32'd100, 32'd7, 32'd2,         1'b0, 1'b1, "remu");
        run_op(0, C_DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, "divu_zero");
        run_op(0, C_REMU, 32'd5,   32'd0, 32'd5,         1'b0, 1'b1, "remu_zero");

        // start held high during a divide: the ADD waits for the done cycle
        start32 = 1'b1; ctrl32 = C_DIVU; a32 = 32'd100; b32 = 32'd7;
        exp32_q.push_back({1'b0, 1'b0, 32'd14});
        @(posedge clk); #1;
        ctrl32 = C_ADD; a32 = 32'd3; b32 = 32'd4;
        exp32_q.push_back({1'b0, 1'b0, 32'd7});
        cyc = 0;
        while (done32 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold_div_latency", 64'(cyc), 64'd32);
        @(posedge clk); #1;
        start32 = 1'b0;
        chk("hold_add_done", 64'(done32), 64'd1);
        chk("hold_add_busy", 64'(busy32), 64'd0);
        @(posedge clk); #1;
        chk("hold_add_single_pulse", 64'(done32), 64'd0);

        // 8-bit instance
        run_op(1, C_MUL,  32'd15,  32'd17, 32'hFF, 1'b0, 1'b1, "mul8");
        run_op(1, C_DIVU, 32'd200, 32'd3,  32'd66, 1'b0, 1'b1, "divu8");
        run_op(1, C_REMU, 32'd200, 32'd3,  32'd2,  1'b0, 1'b1, "remu8");
        run_op(1, C_ADD,  32'h7F,  32'h1,  32'h80, 1'b1, 1'b0, "add8_ovf");
        run_op(1, C_BAD,  32'd5,   32'd3,  32'd0,  1'b0, 1'b0, "bad8");

        repeat (3) @(posedge clk);
        #1;
        chk("pending32", 64'(exp32_q.size()), 64'd0);
        chk("pending8", 64'(exp8_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU.
- Keeps the existing logic/arithmetic control codes, which complete in 1 cycle.
- Adds iterative multiply, unsigned divide and unsigned remainder, which take WIDTH cycles.
- Uses a start/busy/done handshake and adds signed-overflow and zero flags; sits in the EX stage of the multi-cycle datapath, which stalls on busy_o.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64.
CTRL_W, 4, width of ctrl_i.

Ports:
clk_i  input  1  clock; all state changes on rising edge.
rst_i  input  1  asynchronous reset, active-low.
start_i  input  1  request; sampled only when busy_o=0.
src1_i  input  WIDTH  operand A; captured on the accepting edge.
src2_i  input  WIDTH  operand B; captured on the accepting edge.
ctrl_i  input  CTRL_W  operation code; captured on the accepting edge.
result_o  output  WIDTH  registered result; holds until the next completion.
zero_o  output  1  registered; 1 iff result_o == 0.
ovf_o  output  1  registered signed overflow; ADD/SUB only, else 0.
busy_o  output  1  1 while an iterative op is in progress.
done_o  output  1  one-cycle pulse on the cycle a new result_o is valid.

Behaviour:
- Reset (rst_i=0, asynchronous, any state): state=IDLE, result_o=0, zero_o=1, ovf_o=0, busy_o=0, done_o=0, internal counter/accumulators=0. An in-flight op is discarded with no done_o.
- Op codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 12 NOR.
  - 7 SLT: signed, result 1 or 0.
  - 8 SLTU: unsigned.
  - 3 MUL: low WIDTH bits of the product; signedness does not matter for the low half.
  - 5 DIVU: unsigned quotient.
  - 9 REMU: unsigned remainder.
  - Any other code: result 0, single-cycle.
- Arithmetic rules: ADD/SUB wrap modulo 2^WIDTH. ovf_o=1 when:
  - ADD: operand signs are equal and the result sign differs.
  - SUB: operand signs differ and the result sign differs from src1.
- States: IDLE, MUL, DIV.
- Accept: edge where state=IDLE and start_i=1.
- Single-cycle ops:
  - At the accepting edge: result_o/zero_o/ovf_o are loaded, done_o=1 for the following cycle, state stays IDLE.
  - A new start_i in that done_o cycle is accepted (back-to-back throughput 1/cycle).
- MUL (shift-add, 1 multiplier bit per cycle):
  - At the accepting edge: state=MUL, busy_o=1, count=WIDTH, accumulator=0.
  - Each following edge: one iteration, count-1.
  - On the edge where count reaches 0 (WIDTH edges after accept): result_o loaded, state=IDLE, busy_o=0, done_o=1 for one cycle.
  - Latency from accept edge to result edge = WIDTH cycles.
- DIVU/REMU (restoring, 1 quotient bit per cycle): same timing as MUL via state=DIV. DIVU selects the quotient, REMU the remainder.
- Divide by zero: no iteration skipping, latency still WIDTH. DIVU result = all ones; REMU result = src1.
- ovf_o=0 for MUL/DIV/REM/SLT/logic ops.
- start_i while busy_o=1: ignored, with no queueing. Operand/ctrl inputs may change freely after acceptance.
- done_o never asserts without a preceding accept; it is never high for 2 consecutive cycles from one op.
- zero_o always equals (result_o==0), including after reset.
- Outputs hold their values between completions.

Test Plan:
1. Reset mid-MUL: accept MUL 7*9, assert rst_i low 5 cycles later, release -> result_o=0, zero_o=1, busy_o=0, no done_o pulse; next ADD 1+1 -> result_o=2 after 1 cycle.
2. Single-cycle ops back-to-back, WIDTH=32:
   - ADD 0x7FFFFFFF+1 -> 0x80000000, ovf_o=1.
   - SUB 5-5 -> 0, zero_o=1.
   - SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
   - NOR 0,0 -> 0xFFFFFFFF.
   - done_o high on each of the 5 consecutive cycles.
3. MUL 0x0001_0003*0x0000_0005 -> 0x0005_000F; busy_o high exactly 32 cycles; done_o pulses once on the result cycle; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
4. DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; each with 32-cycle latency.
5. start_i held high with ADD operands during a DIVU -> ignored; the ADD is accepted on the done_o cycle of the DIVU and completes 1 cycle later.
6. WIDTH=8 instance: MUL 15*17 -> 0xFF; DIVU 200/3 -> 66; busy_o high 8 cycles; unknown ctrl 15 -> result_o 0, zero_o=1.
